mont_exp_ctrl: RTL and testbench

- Sequencer that computes result = in_x^e mod in_m using left-to-right square-and-multiply.
- Drives one external `montgomery` multiplier instance (512-bit start/done datapath) through a master port.
- Handles conversion into and out of the Montgomery domain using caller-supplied R mod M and R^2 mod M.
- Sits between the top-level RSA command logic and the shared `montgomery` core.

---
 rtl/mont_exp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Drives one external Montgomery multiplier through a start/done master port.
module mont_exp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_e_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  input  logic [WIDTH-1:0]     in_r2,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TOMONT_ISSUE, S_TOMONT_WAIT,
    S_SQ_ISSUE,     S_SQ_WAIT,
    S_MUL_ISSUE,    S_MUL_WAIT,
    S_FROM_ISSUE,   S_FROM_WAIT,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     xm_q;      // base in Montgomery form
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     acc_q;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     mm_a_q, mm_b_q, mm_m_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 len_zero_q;
  logic                 done_q, busy_q, mm_start_q;

  logic [LEN_W-1:0]     len_c;
  logic                 last_bit;

  always_comb begin
    len_c    = (in_e_len > LEN_W'(EXP_WIDTH)) ? LEN_W'(EXP_WIDTH) : in_e_len;
    last_bit = (idx_q == '0);
  end

  // Operands for each multiply are loaded on the edge that enters its ISSUE
  // state, so mm_start and mm_a/mm_b rise together and stay put through WAIT.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      xm_q       <= '0;
      r_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      e_q        <= '0;
      idx_q      <= '0;
      len_zero_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            e_q        <= in_e;
            r_q        <= in_r;
            len_zero_q <= (len_c == '0);
            idx_q      <= IDX_W'(len_c - LEN_W'(1));
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            mm_start_q <= 1'b1;
            mm_a_q     <= in_x;
            mm_b_q     <= in_r2;
            mm_m_q     <= in_m;
            state_q    <= S_TOMONT_ISSUE;
          end
        end
        S_TOMONT_ISSUE: state_q <= S_TOMONT_WAIT;
        S_SQ_ISSUE:     state_q <= S_SQ_WAIT;
        S_MUL_ISSUE:    state_q <= S_MUL_WAIT;
        S_FROM_ISSUE:   state_q <= S_FROM_WAIT;
        S_TOMONT_WAIT: begin
          if (mm_done) begin
            xm_q       <= mm_result;
            acc_q      <= r_q;
            mm_start_q <= 1'b1;
            mm_a_q     <= r_q;
            if (len_zero_q) begin
              mm_b_q  <= WIDTH'(1);
              state_q <= S_FROM_ISSUE;
            end else begin
              mm_b_q  <= r_q;
              state_q <= S_SQ_ISSUE;
            end
          end
        end
        S_SQ_WAIT: begin
          if (mm_done) begin
            acc_q      <= mm_result;
            mm_start_q <= 1'b1;
            mm_a_q     <= mm_result;
            if (e_q[idx_q]) begin
              mm_b_q  <= xm_q;
              state_q <= S_MUL_ISSUE;
            end else if (last_bit) begin
              mm_b_q  <= WIDTH'(1);
              state_q <= S_FROM_ISSUE;
            end else begin
              mm_b_q  <= mm_result;
              idx_q   <= idx_q - IDX_W'(1);
              state_q <= S_SQ_ISSUE;
            end
          end
        end
        S_MUL_WAIT: begin
          if (mm_done) begin
            acc_q      <= mm_result;
            mm_start_q <= 1'b1;
            mm_a_q     <= mm_result;
            if (last_bit) begin
              mm_b_q  <= WIDTH'(1);
              state_q <= S_FROM_ISSUE;
            end else begin
              mm_b_q  <= mm_result;
              idx_q   <= idx_q - IDX_W'(1);
              state_q <= S_SQ_ISSUE;
            end
          end
        end
        S_FROM_WAIT: begin
          if (mm_done) begin
            acc_q   <= mm_result;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a bit-serial Montgomery multiplier model (latency 3).
module tb_mont_exp_ctrl;

  localparam int W = 512;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_x = '0, in_e = '0, in_m = '0, in_r = '0, in_r2 = '0;
  logic [9:0]    in_e_len = '0;
  logic [W-1:0]  result, mm_a, mm_b, mm_m, mm_result;
  logic          done, busy, mm_start, mm_done;

  int n_cmp = 0;
  int n_bad = 0;

  mont_exp_ctrl #(.WIDTH(W), .EXP_WIDTH(W), .LEN_W(10)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_e_len(in_e_len), .in_m(in_m),
    .in_r(in_r), .in_r2(in_r2),
    .result(result), .done(done), .busy(busy),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  // a*b*2^-512 mod m, radix-2 interleaved reduction
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] m);
    logic [W+1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[W-1:0];
  endfunction

  logic [2:0]   dpipe = '0;
  logic [W-1:0] stub_res = '0;
  logic         inj = 1'b0;
  logic         spur_en = 1'b0;
  int           pulse_cnt = 0;

  always @(posedge clk) begin
    dpipe <= {dpipe[1:0], mm_start};
    if (mm_start) stub_res <= mont(mm_a, mm_b, mm_m);
    if (mm_start) pulse_cnt <= pulse_cnt + 1;
  end

  // Optional garbage done pulse overlapping each ISSUE cycle
  always @(negedge clk) inj = spur_en & mm_start;

  assign mm_done   = dpipe[2] | inj;
  assign mm_result = inj ? {W{1'b1}} : stub_res;

  task automatic run_job(input logic [W-1:0] x, input logic [W-1:0] e, input logic [9:0] len,
                         input logic [W-1:0] m, input logic [W-1:0] r, input logic [W-1:0] r2,
                         input int restart_at,
                         output logic [W-1:0] res, output int lat, output int pulses,
                         output logic busy1, output logic tmo);
    int p0;
    int k;
    @(negedge clk);
    in_x = x; in_e = e; in_e_len = len; in_m = m; in_r = r; in_r2 = r2;
    start = 1'b1;
    p0 = pulse_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    busy1 = 1'b0;
    tmo = 1'b1;
    while (k < 5000) begin
      @(posedge clk);
      k++;
      #1;
      start = (k == restart_at);
      if (k == 1) busy1 = busy;
      if (done) begin
        tmo = 1'b0;
        break;
      end
    end
    start = 1'b0;
    res = result;
    lat = k;
    pulses = pulse_cnt - p0;
  endtask

  logic [W-1:0] rs;
  int           lt, pc;
  logic         b1, to;

  task automatic test_reset;
    #12;
    n_cmp++; if (result !== '0)   begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (mm_start !== 1'b0) begin n_bad++; $display("FAIL reset_mm_start got %b want 0", mm_start); end
    n_cmp++; if (mm_a !== '0 || mm_b !== '0 || mm_m !== '0)
      begin n_bad++; $display("FAIL reset_operands got a=%h b=%h m=%h want 0", mm_a, mm_b, mm_m); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_job(input string nm, input logic [W-1:0] exp_res, input int exp_lat,
                           input int exp_pulses);
    n_cmp++; if (to) begin n_bad++; $display("FAIL %s_timeout got no done want done", nm); end
    n_cmp++; if (rs !== exp_res) begin n_bad++; $display("FAIL %s_result got %h want %h", nm, rs, exp_res); end
    n_cmp++; if (lt !== exp_lat) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", nm, lt, exp_lat); end
    n_cmp++; if (pc !== exp_pulses) begin n_bad++; $display("FAIL %s_pulses got %0d want %0d", nm, pc, exp_pulses); end
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL %s_busy got %b want 1", nm, b1); end
  endtask

  // M=13, R=2^512 mod 13=9, R2=3, x=4: 4^13 mod 13 = 4, N = 2+4+3 = 9
  task automatic test_sq_mul;
    run_job(4, 'hD, 4, 13, 9, 3, -1, rs, lt, pc, b1, to);
    check_job("sq_mul", 4, 37, 9);
  endtask

  // only e[1:0]=3 is used: 4^3 = 64 mod 13 = 12, N = 2+2+2 = 6
  task automatic test_len_mask;
    run_job(4, {W{1'b1}}, 2, 13, 9, 3, -1, rs, lt, pc, b1, to);
    check_job("len_mask", 12, 25, 6);
  endtask

  task automatic test_len_zero;
    run_job(4, 'hD, 0, 13, 9, 3, -1, rs, lt, pc, b1, to);
    check_job("len_zero", 1, 9, 2);
  endtask

  task automatic test_e_zero;
    run_job(4, 0, 4, 13, 9, 3, -1, rs, lt, pc, b1, to);
    check_job("e_zero", 1, 25, 6);
  endtask

  task automatic test_restart_ignored;
    run_job(4, 'hD, 4, 13, 9, 3, 10, rs, lt, pc, b1, to);
    check_job("restart", 4, 37, 9);
  endtask

  task automatic test_spurious_done;
    spur_en = 1'b1;
    run_job(4, 'hD, 4, 13, 9, 3, -1, rs, lt, pc, b1, to);
    spur_en = 1'b0;
    check_job("spurious", 4, 37, 9);
  endtask

  // len 600 clamps to 512; e=1 -> 4^1, N = 2+512+1
  task automatic test_len_clamp;
    run_job(4, 1, 10'd600, 13, 9, 3, -1, rs, lt, pc, b1, to);
    check_job("clamp", 4, 515 * 4 + 1, 515);
  endtask

  task automatic test_reset_abort;
    bit seen_done;
    @(negedge clk);
    in_x = 4; in_e = 'hD; in_e_len = 4; in_m = 13; in_r = 9; in_r2 = 3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    n_cmp++; if (result !== '0 || done !== 1'b0 || busy !== 1'b0)
      begin n_bad++; $display("FAIL abort_status got r=%h d=%b b=%b want 0", result, done, busy); end
    n_cmp++; if (mm_start !== 1'b0 || mm_a !== '0 || mm_b !== '0 || mm_m !== '0)
      begin n_bad++; $display("FAIL abort_master got s=%b a=%h b=%h m=%h want 0", mm_start, mm_a, mm_b, mm_m); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    n_cmp++; if (seen_done) begin n_bad++; $display("FAIL abort_quiet got activity want idle"); end
    run_job(4, 'hD, 4, 13, 9, 3, -1, rs, lt, pc, b1, to);
    check_job("after_abort", 4, 37, 9);
  endtask

  task automatic test_wide;
    logic [W-1:0]   m, x, r, r2, want;
    logic [2*W-1:0] big, tmp;
    m = '0; m[W-1] = 1'b1; m[15:0] = 16'h3039;
    x = '0; x[W-2] = 1'b1; x[9:0] = 10'd777;
    big = '0; big[W] = 1'b1;
    tmp = big % {{W{1'b0}}, m};
    r = tmp[W-1:0];
    tmp = ({{W{1'b0}}, r} * {{W{1'b0}}, r}) % {{W{1'b0}}, m};
    r2 = tmp[W-1:0];
    run_job(x, 1, 1, m, r, r2, -1, rs, lt, pc, b1, to);
    check_job("wide_e1", x, 4 * 4 + 1, 4);
    tmp = ({{W{1'b0}}, x} * {{W{1'b0}}, x}) % {{W{1'b0}}, m};
    want = tmp[W-1:0];
    run_job(x, 2, 2, m, r, r2, -1, rs, lt, pc, b1, to);
    check_job("wide_e2", want, 5 * 4 + 1, 5);
  endtask

  initial begin
    test_reset;
    test_sq_mul;
    test_len_mask;
    test_len_zero;
    test_e_zero;
    test_restart_ignored;
    test_spurious_done;
    test_len_clamp;
    test_reset_abort;
    test_wide;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
